imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned IMEM_DEPTH = 1024;

    // Byte lanes within a 32-bit little-endian word
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [1:0]  LANE_FIRST     = 2'd0;
    localparam logic [1:0]  LANE_LAST      = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into a 32-bit little-endian word; shared by header and data.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [BYTE_W-1:0]   data,
    output logic [31:0]         word,
    output logic                word_full
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;

    // word is the packed value including the byte being accepted this cycle
    assign word      = {data, sr_q[31:BYTE_W]};
    assign word_full = en && (cnt_q == LANE_LAST);

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clr) begin
            cnt_d = LANE_FIRST;
            sr_d  = '0;
        end else if (en) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LANE_FIRST;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: streams a length-prefixed image into instruction memory,
// holding the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst_n
);

    state_e      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic        s_ready_q, s_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;

    logic        accept;
    logic        can_start;
    logic        pk_clr;
    logic [31:0] pk_word;
    logic        pk_full;

    assign accept    = s_valid && s_ready_q;
    assign can_start = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
    assign pk_clr    = start && can_start;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pk_clr),
        .en        (accept),
        .data      (s_data),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLen;
                    len_d      = '0;
                    word_idx_d = '0;
                end
            end
            StLen: begin
                if (pk_full) begin
                    len_d = pk_word;
                    if (pk_word == 32'd0) begin
                        state_d = StDone;
                    end else if (pk_word > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (pk_full) begin
                    state_d     = StWrite;
                    mem_addr_d  = word_idx_q << 2;
                    mem_wdata_d = pk_word;
                end
            end
            StWrite: begin
                if (word_idx_q == len_q - 32'd1) begin
                    state_d = StDone;
                end else begin
                    word_idx_d = word_idx_q + 32'd1;
                    state_d    = StData;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they are registered yet cycle-exact
        s_ready_d   = (state_d == StLen) || (state_d == StData);
        mem_we_d    = (state_d == StWrite);
        busy_d      = (state_d == StLen) || (state_d == StData) || (state_d == StWrite);
        done_d      = (state_d == StDone);
        err_d       = (state_d == StErr);
        cpu_rst_n_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            word_idx_q  <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected writes go through a scoreboard queue.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    int unsigned gap_max = 0;
    logic [31:0] last_addr = '0;
    logic [63:0] exp_q[$];

    imem_loader #(.DEPTH(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (mem_we) begin
            logic [63:0] e;
            wr_cnt++;
            last_addr = mem_addr;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr=%h data=%h expected no write",
                       mem_addr, mem_wdata);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("write_addr", mem_addr, e[63:32]);
                chk("write_data", mem_wdata, e[31:0]);
            end
            chk("ready_in_write", {31'd0, s_ready}, 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        int unsigned gap = $urandom_range(0, gap_max);
        repeat (gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL byte_timeout: observed s_ready=0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_u32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
        exp_q.push_back({addr, w});
        send_u32(w);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    endtask

    task automatic load_two_word_image(input string tag);
        send_u32(32'd2);
        send_word(32'h0, 32'h0000_0013);
        send_word(32'h4, 32'h0010_0093);
        // Returned inside the WRITE cycle of the last word
        chk({tag, "_last_we"}, {31'd0, mem_we}, 32'd1);
        chk({tag, "_last_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_ready;
        int wr_before;

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, s_ready}, 32'd0);

        // Full-rate two-word image
        pulse_start();
        chk("s1_busy", {31'd0, busy}, 32'd1);
        chk("s1_ready", {31'd0, s_ready}, 32'd1);
        load_two_word_image("s1");
        seen_ready = 0;
        s_valid = 1'b1;
        s_data = 8'hAA;
        repeat (6) begin
            @(negedge clk);
            if (s_ready) seen_ready++;
        end
        s_valid = 1'b0;
        chk("s1_no_ready_after_done", seen_ready, 32'd0);
        chk("s1_done_sticky", {31'd0, done}, 32'd1);

        // Zero-length header
        wr_before = wr_cnt;
        pulse_start();
        chk("s2_done_cleared", {31'd0, done}, 32'd0);
        chk("s2_cpu_rst_low", {31'd0, cpu_rst_n}, 32'd0);
        send_u32(32'd0);
        chk("s2_done", {31'd0, done}, 32'd1);
        chk("s2_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("s2_busy", {31'd0, busy}, 32'd0);
        chk("s2_no_writes", wr_cnt - wr_before, 32'd0);

        // Oversized header (1025)
        wr_before = wr_cnt;
        pulse_start();
        send_u32(32'd1025);
        chk("s3_err", {31'd0, err}, 32'd1);
        chk("s3_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("s3_done", {31'd0, done}, 32'd0);
        chk("s3_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        chk("s3_err_sticky", {31'd0, err}, 32'd1);
        chk("s3_no_writes", wr_cnt - wr_before, 32'd0);
        pulse_start();
        chk("s3_err_cleared", {31'd0, err}, 32'd0);
        load_two_word_image("s3r");

        // Random s_valid gaps, plus a start pulse while busy that must be ignored
        gap_max = 3;
        pulse_start();
        send_u32(32'd2);
        send_byte(8'h13);
        send_byte(8'h00);
        pulse_start();
        chk("s4_start_ignored_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back({32'h0, 32'h0000_0013});
        send_byte(8'h00);
        send_byte(8'h00);
        send_word(32'h4, 32'h0010_0093);
        chk("s4_last_we", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        chk("s4_done", {31'd0, done}, 32'd1);
        chk("s4_pending", exp_q.size(), 32'd0);
        gap_max = 0;

        // Reset after 6 accepted bytes, then a clean reload
        wr_before = wr_cnt;
        pulse_start();
        send_u32(32'd2);
        send_byte(8'h13);
        send_byte(8'h00);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("s5");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("s5_no_writes", wr_cnt - wr_before, 32'd0);
        pulse_start();
        load_two_word_image("s5r");

        // Maximum length image
        wr_before = wr_cnt;
        pulse_start();
        send_u32(32'd1024);
        chk("s6_not_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = 32'h0302_0100 + 32'(i) * 32'h0404_0404;
            send_word(32'(i) * 32'd4, w);
        end
        @(negedge clk);
        chk("s6_write_count", wr_cnt - wr_before, 32'd1024);
        chk("s6_last_addr", last_addr, 32'h0000_0FFC);
        chk("s6_done", {31'd0, done}, 32'd1);
        chk("s6_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("s6_pending", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
